// File: rtl/irq_controller.sv
// Edge-latching interrupt controller: pending/mask registers on the peripheral bus and a
// fixed-priority (lowest index wins) req/ack/EOI handshake towards the CPU.
module irq_controller #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [1:0]       address,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  input  logic [N_SRC-1:0] irq_src,
  output logic             cpu_irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             cpu_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   src_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   one_hot_id;
  logic [N_SRC-1:0]   clr_sw;
  logic [N_SRC-1:0]   clr_ack;
  logic [ID_W-1:0]    lowest_id;
  logic               id_eligible;
  logic               ack_take;
  logic               wr_pending, wr_mask, wr_eoi;
  logic               unused_wdata;

  assign wr_pending = MemWrite && (address == 2'd0);
  assign wr_mask    = MemWrite && (address == 2'd1);
  assign wr_eoi     = MemWrite && (address == 2'd3);

  // Only the low N_SRC bits of a write are meaningful; the rest are deliberately dropped.
  assign unused_wdata = ^write_data;

  assign rise        = irq_src & ~src_q;
  assign eligible    = pending_q & mask_q;
  assign one_hot_id  = N_SRC'(1) << id_q;
  assign id_eligible = |(eligible & one_hot_id);

  // Scanning from the top down lets the lowest set index overwrite the result last.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    lowest_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) lowest_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ack_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQ;
          id_d    = lowest_id;
        end
      end
      REQ: begin
        // The id is frozen while requesting; only ack or withdrawal moves us on.
        if (cpu_ack) begin
          state_d  = SERVICE;
          ack_take = 1'b1;
        end else if (!id_eligible) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_sw  = wr_pending ? write_data[N_SRC-1:0] : '0;
  assign clr_ack = ack_take ? one_hot_id : '0;

  // A new rising edge wins over a clear landing on the same bit in the same cycle.
  assign pending_d = (pending_q & ~clr_sw & ~clr_ack) | rise;
  assign mask_d    = wr_mask ? write_data[N_SRC-1:0] : mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      id_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      src_q     <= irq_src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
    end
  end

  assign cpu_irq = (state_q == REQ);
  assign irq_id  = id_q;

  always_comb begin
    read_data = '0;
    if (MemRead) begin
      unique case (address)
        2'd0:    read_data = 32'(pending_q);
        2'd1:    read_data = 32'(mask_q);
        2'd2:    read_data = (32'(state_q) << 8) | 32'(id_q);
        default: read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a vector table applied through a scoreboard queue,
// followed by hand-written reset sequences.
module tb_irq_controller;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             MemRead;
  logic             MemWrite;
  logic [1:0]       address;
  logic [31:0]      write_data;
  logic [31:0]      read_data;
  logic [N_SRC-1:0] irq_src;
  logic             cpu_irq;
  logic [ID_W-1:0]  irq_id;
  logic             cpu_ack;

  irq_controller #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .irq_src    (irq_src),
    .cpu_irq    (cpu_irq),
    .irq_id     (irq_id),
    .cpu_ack    (cpu_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  src;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        irq;
    logic [2:0]  id;
    logic [7:0]  pend;
    logic [7:0]  mask;
    logic [1:0]  st;
  } vec_t;

  typedef struct {
    logic        irq;
    logic [2:0]  id;
    logic [7:0]  pend;
    logic [7:0]  mask;
    logic [1:0]  st;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    MemRead = 1'b1;
    address = a;
    #1;
    d = read_data;
    MemRead = 1'b0;
    address = 2'd0;
  endtask

  function automatic vec_t mk(input logic [7:0] src, input logic wr, input logic [1:0] addr,
                              input logic [31:0] wdata, input logic ack, input logic irq,
                              input logic [2:0] id, input logic [7:0] pend,
                              input logic [7:0] mask, input logic [1:0] st);
    vec_t v;
    v.src = src; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack;
    v.irq = irq; v.id = id; v.pend = pend; v.mask = mask; v.st = st;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    exp_t        e;

    //               src    wr addr wdata          ack irq id pend   mask   st
    // Mask/priority basics with ack and EOI (upper mask write bits ignored).
    vecs.push_back(mk(8'h00, 1, 2'd1, 32'hFFFF_FF01, 0, 0, 0, 8'h00, 8'h01, 2'd0));
    vecs.push_back(mk(8'h01, 0, 2'd0, 32'h0,         0, 0, 0, 8'h01, 8'h01, 2'd0));
    vecs.push_back(mk(8'h00, 0, 2'd0, 32'h0,         0, 1, 0, 8'h01, 8'h01, 2'd1));
    vecs.push_back(mk(8'h00, 0, 2'd0, 32'h0,         1, 0, 0, 8'h00, 8'h01, 2'd2));
    vecs.push_back(mk(8'h00, 1, 2'd3, 32'hDEAD_BEEF, 0, 0, 0, 8'h00, 8'h01, 2'd0));
    // Simultaneous sources 5 and 2: lowest wins, the other follows after EOI.
    vecs.push_back(mk(8'h00, 1, 2'd1, 32'h0000_00FF, 0, 0, 0, 8'h00, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h24, 0, 2'd0, 32'h0,         0, 0, 0, 8'h24, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h24, 0, 2'd0, 32'h0,         0, 1, 2, 8'h24, 8'hFF, 2'd1));
    vecs.push_back(mk(8'h24, 0, 2'd0, 32'h0,         1, 0, 2, 8'h20, 8'hFF, 2'd2));
    vecs.push_back(mk(8'h24, 1, 2'd3, 32'h0,         0, 0, 2, 8'h20, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h24, 0, 2'd0, 32'h0,         0, 1, 5, 8'h20, 8'hFF, 2'd1));
    vecs.push_back(mk(8'h24, 0, 2'd0, 32'h0,         1, 0, 5, 8'h00, 8'hFF, 2'd2));
    vecs.push_back(mk(8'h00, 1, 2'd3, 32'h0,         0, 0, 5, 8'h00, 8'hFF, 2'd0));
    // Withdrawal by software clear in REQ; status write and stray ack ignored.
    vecs.push_back(mk(8'h00, 1, 2'd1, 32'h0000_0008, 0, 0, 5, 8'h00, 8'h08, 2'd0));
    vecs.push_back(mk(8'h08, 0, 2'd0, 32'h0,         0, 0, 5, 8'h08, 8'h08, 2'd0));
    vecs.push_back(mk(8'h00, 0, 2'd0, 32'h0,         0, 1, 3, 8'h08, 8'h08, 2'd1));
    vecs.push_back(mk(8'h00, 1, 2'd0, 32'h0000_0008, 0, 1, 3, 8'h00, 8'h08, 2'd1));
    vecs.push_back(mk(8'h00, 1, 2'd2, 32'hFFFF_FFFF, 0, 0, 3, 8'h00, 8'h08, 2'd0));
    vecs.push_back(mk(8'h00, 0, 2'd0, 32'h0,         1, 0, 3, 8'h00, 8'h08, 2'd0));
    // W1C colliding with a new rise on the same bit.
    vecs.push_back(mk(8'h00, 1, 2'd1, 32'h0000_00FF, 0, 0, 3, 8'h00, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h02, 0, 2'd0, 32'h0,         0, 0, 3, 8'h02, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h00, 0, 2'd0, 32'h0,         0, 1, 1, 8'h02, 8'hFF, 2'd1));
    vecs.push_back(mk(8'h02, 1, 2'd0, 32'h0000_0002, 0, 1, 1, 8'h02, 8'hFF, 2'd1));
    vecs.push_back(mk(8'h02, 1, 2'd0, 32'h0000_0002, 0, 1, 1, 8'h00, 8'hFF, 2'd1));
    vecs.push_back(mk(8'h00, 0, 2'd0, 32'h0,         0, 0, 1, 8'h00, 8'hFF, 2'd0));
    // A held level produces one event only until it drops and rises again.
    vecs.push_back(mk(8'h10, 0, 2'd0, 32'h0,         0, 0, 1, 8'h10, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h10, 0, 2'd0, 32'h0,         0, 1, 4, 8'h10, 8'hFF, 2'd1));
    vecs.push_back(mk(8'h10, 0, 2'd0, 32'h0,         1, 0, 4, 8'h00, 8'hFF, 2'd2));
    vecs.push_back(mk(8'h10, 1, 2'd3, 32'h0,         0, 0, 4, 8'h00, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h10, 0, 2'd0, 32'h0,         0, 0, 4, 8'h00, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h00, 0, 2'd0, 32'h0,         0, 0, 4, 8'h00, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h10, 0, 2'd0, 32'h0,         0, 0, 4, 8'h10, 8'hFF, 2'd0));
    vecs.push_back(mk(8'h10, 0, 2'd0, 32'h0,         0, 1, 4, 8'h10, 8'hFF, 2'd1));
    vecs.push_back(mk(8'h11, 0, 2'd0, 32'h0,         1, 0, 4, 8'h01, 8'hFF, 2'd2));

    reset      = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    address    = 2'd0;
    write_data = '0;
    irq_src    = '0;
    cpu_ack    = 1'b0;

    #1;
    check("reset cpu_irq", 32'(cpu_irq), 32'h0);
    check("reset irq_id", 32'(irq_id), 32'h0);
    read_reg(2'd0, rd); check("reset pending", rd, 32'h0);
    read_reg(2'd2, rd); check("reset status", rd, 32'h0);

    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      irq_src    = vecs[i].src;
      MemWrite   = vecs[i].wr;
      address    = vecs[i].addr;
      write_data = vecs[i].wdata;
      cpu_ack    = vecs[i].ack;
      sb.push_back('{irq: vecs[i].irq, id: vecs[i].id, pend: vecs[i].pend,
                     mask: vecs[i].mask, st: vecs[i].st});
      @(posedge clk);
      #1;
      MemWrite   = 1'b0;
      cpu_ack    = 1'b0;
      write_data = '0;
      address    = 2'd0;
      e = sb.pop_front();
      check($sformatf("v%0d cpu_irq", i), 32'(cpu_irq), 32'(e.irq));
      check($sformatf("v%0d irq_id", i), 32'(irq_id), 32'(e.id));
      read_reg(2'd0, rd); check($sformatf("v%0d pending", i), rd, 32'(e.pend));
      read_reg(2'd1, rd); check($sformatf("v%0d mask", i), rd, 32'(e.mask));
      read_reg(2'd2, rd); check($sformatf("v%0d status", i), rd, {22'b0, e.st, 5'b0, e.id});
    end

    // Read port is quiet without a strobe even though pending is nonzero.
    MemRead = 1'b0;
    address = 2'd0;
    #1;
    check("no-strobe read_data", read_data, 32'h0);
    read_reg(2'd3, rd); check("eoi reads zero", rd, 32'h0);

    // Reset asserted in SERVICE, between clock edges.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst-svc cpu_irq", 32'(cpu_irq), 32'h0);
    check("rst-svc irq_id", 32'(irq_id), 32'h0);
    read_reg(2'd0, rd); check("rst-svc pending", rd, 32'h0);
    read_reg(2'd1, rd); check("rst-svc mask", rd, 32'h0);
    read_reg(2'd2, rd); check("rst-svc status", rd, 32'h0);

    // Sources already high at reset release count as rising edges.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    read_reg(2'd0, rd); check("release-high pending", rd, 32'h11);

    @(negedge clk);
    MemWrite   = 1'b1;
    address    = 2'd1;
    write_data = 32'h01;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    write_data = '0;
    read_reg(2'd2, rd); check("mask-then idle", rd, 32'h0);
    @(posedge clk);
    #1;
    check("req cpu_irq", 32'(cpu_irq), 32'h1);
    check("req irq_id", 32'(irq_id), 32'h0);

    // Reset asserted mid-request drops cpu_irq without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("rst-req cpu_irq", 32'(cpu_irq), 32'h0);
    read_reg(2'd2, rd); check("rst-req status", rd, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
